axi_rd_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one axi_rd helper instance between NUM_REQ requesters.

---
 rtl/axi_rd_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter that shares one axi_rd read helper between NUM_REQ requesters.
// It grants one requester at a time and drives the helper's enable, id, addr and burst_len.
// When the helper reports ok or error, it returns the burst data and a result to the winner.
// Optional watchdog: define AXI_RD_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES.
module axi_rd_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned MAX_BURST_LEN  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQ*4-1:0]                req_len,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [NUM_REQ-1:0]                  done,
  output logic                                err,
  output logic [MAX_BURST_LEN*BUS_WIDTH-1:0]  rdata,
  output logic                                timeout,
  output logic                                rd_enable,
  output logic [ID_WIDTH-1:0]                 rd_id,
  output logic [ADDR_WIDTH-1:0]               rd_addr,
  output logic [3:0]                          rd_burst_len,
  output logic [2:0]                          rd_burst_size,
  input  logic [1:0]                          rd_status,
  input  logic [MAX_BURST_LEN*BUS_WIDTH-1:0]  rd_data
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DATA_W = MAX_BURST_LEN * BUS_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_OK    = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  // Reject parameter combinations the datapath cannot represent
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("axi_rd_arbiter: NUM_REQ must be 2..8");
    end
    if (ID_WIDTH < IDX_W) begin : g_bad_id_width
      $error("axi_rd_arbiter: ID_WIDTH too narrow for NUM_REQ");
    end
    if (BUS_WIDTH < 8 || BUS_WIDTH > 1024 || (BUS_WIDTH & (BUS_WIDTH - 1)) != 0) begin : g_bad_bus_width
      $error("axi_rd_arbiter: BUS_WIDTH must be a power of 2 in 8..1024");
    end
    if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > 16) begin : g_bad_burst
      $error("axi_rd_arbiter: MAX_BURST_LEN must be 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("axi_rd_arbiter: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_REQ-1:0]     gnt_d, done_d;
  logic                   err_d, rd_enable_d;
  logic [ID_WIDTH-1:0]    rd_id_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_d;
  logic [3:0]             rd_burst_len_d;
  logic [DATA_W-1:0]      rdata_d;
  logic                   win_found;
  logic [IDX_W-1:0]       win, cand;

`ifdef AXI_RD_ARB_TIMEOUT_EN
  logic [31:0]            wd_cnt_q, wd_cnt_d;
  logic                   timeout_d;
`endif

  // Helper transfer size is fixed by the bus width
  assign rd_burst_size = 3'($clog2(BUS_WIDTH / 8));

  // Round-robin pick: first requester above the last winner, wrapping
  always_comb begin
    win_found = 1'b0;
    win       = rr_q;
    cand      = rr_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    idx_d          = idx_q;
    gnt_d          = '0;
    done_d         = '0;
    err_d          = 1'b0;
    rd_enable_d    = 1'b0;
    rd_id_d        = rd_id;
    rd_addr_d      = rd_addr;
    rd_burst_len_d = rd_burst_len;
    rdata_d        = rdata;
`ifdef AXI_RD_ARB_TIMEOUT_EN
    wd_cnt_d       = wd_cnt_q;
    timeout_d      = timeout;
`endif

    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d          = NUM_REQ'(1) << win;
          idx_d          = win;
          rr_d           = win;
          rd_id_d        = ID_WIDTH'(win);
          rd_addr_d      = req_addr[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          rd_burst_len_d = req_len[32'(win)*4 +: 4];
          rd_enable_d    = (rd_status == ST_READY);
          state_d        = ISSUE;
        end
      end

      ISSUE: begin
        // One cycle of enable is the whole handshake; otherwise keep waiting for ready
        if (rd_enable) begin
          state_d = WAIT;
`ifdef AXI_RD_ARB_TIMEOUT_EN
          wd_cnt_d = '0;
`endif
        end else begin
          rd_enable_d = (rd_status == ST_READY);
        end
      end

      WAIT: begin
        if (rd_status == ST_OK || rd_status == ST_ERR) begin
          done_d  = NUM_REQ'(1) << idx_q;
          err_d   = (rd_status == ST_ERR);
          rdata_d = rd_data;
          state_d = IDLE;
        end
`ifdef AXI_RD_ARB_TIMEOUT_EN
        else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          done_d    = NUM_REQ'(1) << idx_q;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_q         <= IDX_W'(NUM_REQ - 1);
      idx_q        <= '0;
      gnt          <= '0;
      done         <= '0;
      err          <= 1'b0;
      rd_enable    <= 1'b0;
      rd_id        <= '0;
      rd_addr      <= '0;
      rd_burst_len <= '0;
      rdata        <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      idx_q        <= idx_d;
      gnt          <= gnt_d;
      done         <= done_d;
      err          <= err_d;
      rd_enable    <= rd_enable_d;
      rd_id        <= rd_id_d;
      rd_addr      <= rd_addr_d;
      rd_burst_len <= rd_burst_len_d;
      rdata        <= rdata_d;
    end
  end

`ifdef AXI_RD_ARB_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
      timeout  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      timeout  <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
